mem_wb_stage: RTL and testbench

//  Consumer end of the execute-stage pipeline ports (ALUout/MemOp/rd/MemtoReg/MemWr/RegWr).

---
 rtl/mem_wb_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: dmem handshake, store lane steering, load extension, RegFile write port
// One EX result in flight at a time; IDLE -> (MEM) -> WB, with a new op accepted during WB.
module mem_wb_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] ALUout,
   input  logic [31:0] in_wdata,
   input  logic [2:0]  MemOp,
   input  logic [4:0]  rd,
   input  logic        MemtoReg,
   input  logic        MemWr,
   input  logic        RegWr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t      state_q;
   logic [31:0] addr_q;
   logic [2:0]  op_q;
   logic [4:0]  rd_q;
   logic        load_q;
   logic        regwr_q;
   logic [15:0] cnt_q;

   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic [3:0]  dmem_wmask_q;
   logic        wb_en_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;
   logic        misalign_q;
   logic        bus_err_q;

   // Incoming op decode; a simultaneous MemtoReg & MemWr is treated as a store.
   logic        in_load;
   logic        in_store;
   logic        in_mem;
   logic        in_aligned;
   logic [31:0] st_wdata;
   logic [3:0]  st_wmask;

   always_comb begin
      in_load    = MemtoReg & ~MemWr;
      in_store   = MemWr;
      in_mem     = in_load | in_store;
      in_aligned = 1'b1;
      st_wdata   = in_wdata;
      st_wmask   = 4'b1111;
      case (MemOp[1:0])
         2'b00: begin
            st_wdata = {4{in_wdata[7:0]}};
            st_wmask = 4'b0001 << ALUout[1:0];
         end
         2'b01: begin
            in_aligned = ~ALUout[0];
            st_wdata   = {2{in_wdata[15:0]}};
            st_wmask   = 4'b0011 << {ALUout[1], 1'b0};
         end
         default: begin
            in_aligned = (ALUout[1:0] == 2'b00);
         end
      endcase
   end

   // Load data extraction from the returned word, based on the latched address and op.
   logic [31:0] ld_byte_w;
   logic [31:0] ld_half_w;
   logic [31:0] ld_ext;

   always_comb begin
      ld_byte_w = dmem_rdata >> {addr_q[1:0], 3'b000};
      ld_half_w = dmem_rdata >> {addr_q[1], 4'b0000};
      case (op_q[1:0])
         2'b00:   ld_ext = op_q[2] ? {24'd0, ld_byte_w[7:0]}
                                   : {{24{ld_byte_w[7]}}, ld_byte_w[7:0]};
         2'b01:   ld_ext = op_q[2] ? {16'd0, ld_half_w[15:0]}
                                   : {{16{ld_half_w[15]}}, ld_half_w[15:0]};
         default: ld_ext = dmem_rdata;
      endcase
   end

   logic timed_out;
   assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         op_q         <= '0;
         rd_q         <= '0;
         load_q       <= 1'b0;
         regwr_q      <= 1'b0;
         cnt_q        <= '0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         dmem_wmask_q <= '0;
         wb_en_q      <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         wb_en_q    <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         if (state_q == S_MEM) begin
            if (dmem_ack || timed_out) begin
               state_q      <= S_WB;
               dmem_req_q   <= 1'b0;
               dmem_we_q    <= 1'b0;
               dmem_addr_q  <= '0;
               dmem_wdata_q <= '0;
               dmem_wmask_q <= '0;
               wb_rd_q      <= rd_q;
               if (dmem_ack) begin
                  wb_en_q   <= load_q & regwr_q & (rd_q != 5'd0);
                  wb_data_q <= load_q ? ld_ext : addr_q;
               end else begin
                  bus_err_q <= 1'b1;
                  wb_data_q <= addr_q;
               end
            end else begin
               cnt_q <= cnt_q + 16'd1;
            end
         end else if (in_valid) begin
            addr_q  <= ALUout;
            op_q    <= MemOp;
            rd_q    <= rd;
            load_q  <= in_load;
            regwr_q <= RegWr;
            wb_rd_q <= rd;
            if (in_mem && in_aligned) begin
               state_q      <= S_MEM;
               cnt_q        <= '0;
               dmem_req_q   <= 1'b1;
               dmem_we_q    <= in_store;
               dmem_addr_q  <= {ALUout[31:2], 2'b00};
               dmem_wdata_q <= in_store ? st_wdata : 32'd0;
               dmem_wmask_q <= in_store ? st_wmask : 4'b0000;
            end else begin
               state_q    <= S_WB;
               misalign_q <= in_mem;
               wb_en_q    <= ~in_mem & RegWr & (rd != 5'd0);
               wb_data_q  <= ALUout;
            end
         end else begin
            state_q <= S_IDLE;
         end
      end
   end

   assign in_ready   = (state_q != S_MEM);
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign dmem_wmask = dmem_wmask_q;
   assign wb_en      = wb_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign misalign   = misalign_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ALUout;
   logic [31:0] in_wdata;
   logic [2:0]  MemOp;
   logic [4:0]  rd;
   logic        MemtoReg;
   logic        MemWr;
   logic        RegWr;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign;
   logic        bus_err;

   int errors = 0;
   int checks = 0;

   mem_wb_stage #(.TIMEOUT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUout     (ALUout),
      .in_wdata   (in_wdata),
      .MemOp      (MemOp),
      .rd         (rd),
      .MemtoReg   (MemtoReg),
      .MemWr      (MemWr),
      .RegWr      (RegWr),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_wmask (dmem_wmask),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .misalign   (misalign),
      .bus_err    (bus_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] op, input logic [4:0] r,
                        input logic ld, input logic st, input logic rw);
      in_valid = v;
      ALUout   = a;
      in_wdata = d;
      MemOp    = op;
      rd       = r;
      MemtoReg = ld;
      MemWr    = st;
      RegWr    = rw;
   endtask

   task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] op,
                           input logic [4:0] r, input logic [31:0] rdata,
                           input logic exp_en, input logic [31:0] exp_data);
      drive(1'b1, a, 32'd0, op, r, 1'b1, 1'b0, 1'b1);
      step();
      check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      step();
      dmem_ack = 1'b0;
      check({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, exp_en});
      check({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, r});
      check({tag, "_wb_data"}, wb_data, exp_data);
      step();
   endtask

   initial begin
      reset = 1'b0;
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_req", {31'd0, dmem_req}, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wb_en", {31'd0, wb_en}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      #2 reset = 1'b1;
      step();

      // ALU op: write-back one cycle after accept
      drive(1'b1, 32'h1234, 32'd0, 3'd0, 5'd5, 1'b0, 1'b0, 1'b1);
      step();
      check("alu_wb_en", {31'd0, wb_en}, 32'd1);
      check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
      check("alu_wb_data", wb_data, 32'h1234);
      check("alu_no_req", {31'd0, dmem_req}, 32'd0);
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      check("alu_wb_pulse", {31'd0, wb_en}, 32'd0);

      run_load("lb",  32'h103, 3'b000, 5'd7, 32'h80FFFFFF, 1'b1, 32'hFFFFFF80);
      run_load("lbu", 32'h103, 3'b100, 5'd7, 32'h80FFFFFF, 1'b1, 32'h00000080);
      run_load("lh",  32'h102, 3'b001, 5'd8, 32'h80FFFFFF, 1'b1, 32'hFFFF80FF);
      run_load("lhu", 32'h100, 3'b101, 5'd8, 32'h1234ABCD, 1'b1, 32'h0000ABCD);
      run_load("lw_r0", 32'h104, 3'b010, 5'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);

      // Store halfword, ack delayed one cycle
      drive(1'b1, 32'h202, 32'hABCD1234, 3'b001, 5'd3, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("sh_we", {31'd0, dmem_we}, 32'd1);
      check("sh_addr", dmem_addr, 32'h200);
      check("sh_wdata", dmem_wdata, 32'h12341234);
      check("sh_wmask", {28'd0, dmem_wmask}, 32'hC);
      check("sh_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("sh_hold_req", {31'd0, dmem_req}, 32'd1);
      check("sh_hold_wdata", dmem_wdata, 32'h12341234);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("sh_no_wb", {31'd0, wb_en}, 32'd0);
      check("sh_req_drop", {31'd0, dmem_req}, 32'd0);
      step();

      // Store byte in lane 1
      drive(1'b1, 32'h301, 32'h000000A5, 3'b000, 5'd3, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      check("sb_wmask", {28'd0, dmem_wmask}, 32'h2);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      step();

      // Misaligned lw dropped, next op accepted in the WB cycle
      drive(1'b1, 32'h101, 32'd0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b1);
      step();
      check("mis_pulse", {31'd0, misalign}, 32'd1);
      check("mis_no_req", {31'd0, dmem_req}, 32'd0);
      check("mis_wb_en", {31'd0, wb_en}, 32'd0);
      check("mis_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h55, 32'd0, 3'd0, 5'd9, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("mis_pulse_end", {31'd0, misalign}, 32'd0);
      check("next_wb_en", {31'd0, wb_en}, 32'd1);
      check("next_wb_data", wb_data, 32'h55);
      step();

      // Timeout: 4 request cycles, bus_err, late ack ignored
      drive(1'b1, 32'h400, 32'd0, 3'b010, 5'd4, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("to_req_c1", {31'd0, dmem_req}, 32'd1);
      for (int i = 2; i <= 4; i++) begin
         step();
         check($sformatf("to_req_c%0d", i), {31'd0, dmem_req}, 32'd1);
         check($sformatf("to_no_err_c%0d", i), {31'd0, bus_err}, 32'd0);
      end
      step();
      check("to_bus_err", {31'd0, bus_err}, 32'd1);
      check("to_req_drop", {31'd0, dmem_req}, 32'd0);
      check("to_wb_en", {31'd0, wb_en}, 32'd0);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hFFFFFFFF;
      step();
      dmem_ack = 1'b0;
      check("late_ack_wb_en", {31'd0, wb_en}, 32'd0);
      check("late_ack_err", {31'd0, bus_err}, 32'd0);
      check("late_ack_req", {31'd0, dmem_req}, 32'd0);
      check("late_ack_ready", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset in the middle of an access
      drive(1'b1, 32'h504, 32'h11223344, 3'b010, 5'd2, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("ar_req_before", {31'd0, dmem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("ar_req", {31'd0, dmem_req}, 32'd0);
      check("ar_we", {31'd0, dmem_we}, 32'd0);
      check("ar_addr", dmem_addr, 32'd0);
      check("ar_wdata", dmem_wdata, 32'd0);
      check("ar_wmask", {28'd0, dmem_wmask}, 32'd0);
      check("ar_ready", {31'd0, in_ready}, 32'd1);
      #3 reset = 1'b1;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("ar_ack_ignored_wb", {31'd0, wb_en}, 32'd0);
      check("ar_ack_ignored_req", {31'd0, dmem_req}, 32'd0);
      check("ar_ready_after", {31'd0, in_ready}, 32'd1);

      drive(1'b1, 32'hCAFE0001, 32'd0, 3'd0, 5'd31, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("post_rst_wb_en", {31'd0, wb_en}, 32'd1);
      check("post_rst_wb_data", wb_data, 32'hCAFE0001);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
